cu: RTL and testbench

- Main control unit for the RV32I single-cycle/pipelined datapath.
- Decodes the 7-bit instruction opcode into datapath control strobes and a 2-bit ALUOp for the downstream ALU control block.
- Outputs are registered: one clock, asynchronous active-low reset.

---
 rtl/cu_if.sv | 24 ++
 rtl/cu.sv | 31 +++
 tb/tb_cu.sv | 104 ++++++++++
 3 files changed

// File: rtl/cu_if.sv
// cu_if: opcode in, registered control strobes out for the RV32I main control unit.
interface cu_if;
    logic [6:0] operation;
    logic       ALUSrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       Branch;
    logic       Jump;
    logic       Jalr;
    logic [1:0] ALUOp;
    logic       illegal;
    modport master (
        output operation,
        input  ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
        input  Branch, Jump, Jalr, ALUOp, illegal
    );
    modport slave (
        input  operation,
        output ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
        output Branch, Jump, Jalr, ALUOp, illegal
    );
endinterface

// File: rtl/cu.sv
// cu: RV32I main control unit, full-width opcode decode into registered control strobes.
module cu (
    input  logic clk,
    input  logic rst_n,
    cu_if.slave  bus
);
    // row layout: ALUSrc MemtoReg RegWrite MemRead MemWrite Branch Jump Jalr ALUOp[1:0] illegal
    logic [10:0] dec;
    always_comb begin
        dec = 11'b00000000_00_1;
        case (bus.operation)
            7'b0110011: dec = 11'b00100000_10_0;
            7'b0000011: dec = 11'b11110000_00_0;
            7'b0010011: dec = 11'b10100000_11_0;
            7'b0100011: dec = 11'b10001000_00_0;
            7'b1100011: dec = 11'b00000100_01_0;
            7'b1100111: dec = 11'b10100001_00_0;
            7'b1101111: dec = 11'b00100010_00_0;
            default:    dec = 11'b00000000_00_1;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead, bus.MemWrite,
             bus.Branch, bus.Jump, bus.Jalr, bus.ALUOp, bus.illegal} <= '0;
        end else begin
            {bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead, bus.MemWrite,
             bus.Branch, bus.Jump, bus.Jalr, bus.ALUOp, bus.illegal} <= dec;
        end
    end
endmodule

// File: tb/tb_cu.sv
// tb_cu: directed and random checks of the cu decode table, reset behaviour and invariants.
module tb_cu;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    cu_if b ();
    cu dut (.clk(clk), .rst_n(rst_n), .bus(b));
    always #5 clk = ~clk;
    localparam logic [10:0] R_ROW   = 11'b00100000_10_0;
    localparam logic [10:0] LD_ROW  = 11'b11110000_00_0;
    localparam logic [10:0] I_ROW   = 11'b10100000_11_0;
    localparam logic [10:0] ST_ROW  = 11'b10001000_00_0;
    localparam logic [10:0] BR_ROW  = 11'b00000100_01_0;
    localparam logic [10:0] JR_ROW  = 11'b10100001_00_0;
    localparam logic [10:0] JL_ROW  = 11'b00100010_00_0;
    localparam logic [10:0] ILL_ROW = 11'b00000000_00_1;
    function automatic logic [10:0] model(input logic [6:0] op);
        if (op == 7'h33) return R_ROW;
        if (op == 7'h03) return LD_ROW;
        if (op == 7'h13) return I_ROW;
        if (op == 7'h23) return ST_ROW;
        if (op == 7'h63) return BR_ROW;
        if (op == 7'h67) return JR_ROW;
        if (op == 7'h6F) return JL_ROW;
        return ILL_ROW;
    endfunction
    function automatic logic [10:0] row();
        return {b.ALUSrc, b.MemtoReg, b.RegWrite, b.MemRead, b.MemWrite,
                b.Branch, b.Jump, b.Jalr, b.ALUOp, b.illegal};
    endfunction
    task automatic chk(input string tag, input logic [10:0] exp);
        logic [10:0] got;
        got = row();
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: observed %b expected %b", tag, got, exp);
            $error("%s observed %b expected %b", tag, got, exp);
        end
    endtask
    task automatic step(input string tag, input logic [6:0] op, input logic [10:0] exp);
        @(negedge clk);
        b.operation = op;
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask
    initial begin
        rst_n = 1'b0;
        b.operation = 7'b0110011;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", 11'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_after_reset", R_ROW);
        step("rtype", 7'b0110011, R_ROW);
        step("load",  7'b0000011, LD_ROW);
        step("jalr",  7'b1100111, JR_ROW);
        step("itype", 7'b0010011, I_ROW);
        step("store", 7'b0100011, ST_ROW);
        step("branch", 7'b1100011, BR_ROW);
        step("jal",   7'b1101111, JL_ROW);
        step("ill_00", 7'b0000000, ILL_ROW);
        step("ill_7f", 7'b1111111, ILL_ROW);
        step("ill_lui", 7'b0110111, ILL_ROW);
        step("ill_lowbits", 7'b0110010, ILL_ROW);
        step("load_again", 7'b0000011, LD_ROW);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 11'b0);
        @(posedge clk);
        #1;
        chk("async_reset_edge", 11'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("after_async", 7'b0100011, ST_ROW);
        for (int i = 0; i < 1000; i++) begin
            logic [6:0] op;
            op = 7'($urandom_range(0, 127));
            step("random", op, model(op));
            checks++;
            assert (!(b.MemRead && b.MemWrite)) else begin
                errors++;
                $display("FAIL mem_excl: op %b observed rd=%b wr=%b expected not both", op, b.MemRead, b.MemWrite);
                $error("mem_excl");
            end
            checks++;
            assert ((32'(b.Branch) + 32'(b.Jump) + 32'(b.Jalr)) <= 1) else begin
                errors++;
                $display("FAIL ctl_onehot: op %b observed %b%b%b expected at most one", op, b.Branch, b.Jump, b.Jalr);
                $error("ctl_onehot");
            end
        end
        step("x_input", 7'bx, ILL_ROW);
        step("recover", 7'b1100111, JR_ROW);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
